// File: rtl/disp_arbiter_if.sv
// Display-arbiter bus bundle.
// Purpose: groups the requester-side signals and the arbitrated display
//          output of disp_arbiter into one interface.
// Signals:
//   req    [N_REQ]     per-requester display request, level-sensitive
//   data   [32*N_REQ]  flattened segment clusters, requester k owns [32k+31:32k]
//   gnt    [N_REQ]     one-hot grant, all-zero when idle
//   owner  [3]         index of granted requester (0 when idle)
//   busy               high while a grant is active
//   number [32]        registered segment cluster for the display driver
// Modports: master = requester/driver side, slave = arbiter side.
interface disp_arbiter_if #(
    parameter int N_REQ = 3
);
    logic [N_REQ-1:0]    req;
    logic [32*N_REQ-1:0] data;
    logic [N_REQ-1:0]    gnt;
    logic [2:0]          owner;
    logic                busy;
    logic [31:0]         number;

    modport master (
        output req, data,
        input  gnt, owner, busy, number
    );

    modport slave (
        input  req, data,
        output gnt, owner, busy, number
    );
endinterface

// File: rtl/disp_arbiter.sv
// disp_arbiter: shares one 4-digit 7-segment display driver between N_REQ
// requesters. Round-robin arbitration with a minimum dwell time per grant;
// a blank pattern is shown while nobody holds the display.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   bus     disp_arbiter_if.slave (req/data in, gnt/owner/busy/number out)
module disp_arbiter #(
    parameter int          N_REQ = 3,
    parameter int          DWELL = 4_000_000,
    parameter int          CNT_W = 23,
    parameter logic [31:0] BLANK = 32'hFFFF_FFFF
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    disp_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DWELL - 1);
    localparam logic [2:0]       PTR_RESET = 3'(N_REQ - 1);

    state_t           state_reg,  state_next;
    logic [2:0]       owner_reg,  owner_next;
    logic [2:0]       ptr_reg,    ptr_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [31:0]      number_reg, number_next;

    // Requests and data widened to 8 entries so 3-bit indices are exact.
    logic [7:0]  req_ext;
    logic [31:0] slice_ext [8];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ext
            if (gi < N_REQ) begin : g_used
                assign req_ext[gi]   = bus.req[gi];
                assign slice_ext[gi] = bus.data[32*gi +: 32];
            end else begin : g_unused
                assign req_ext[gi]   = 1'b0;
                assign slice_ext[gi] = BLANK;
            end
        end
        for (gi = 0; gi < N_REQ; gi++) begin : g_gnt
            assign bus.gnt[gi] = (state_reg == GRANT) && (owner_reg == 3'(gi));
        end
    endgenerate

    assign bus.owner  = owner_reg;
    assign bus.busy   = (state_reg == GRANT);
    assign bus.number = number_reg;

    // Round-robin search starting after the last winner. While granted the
    // current owner is skipped so only a genuine competitor is found.
    logic       win_found;
    logic [2:0] win_idx;
    logic [2:0] cand;

    always_comb begin
        win_found = 1'b0;
        win_idx   = 3'd0;
        cand      = 3'd0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = 3'((int'(ptr_reg) + off) % N_REQ);
            if (!win_found && req_ext[cand] &&
                !((state_reg == GRANT) && (cand == owner_reg))) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        owner_next  = owner_reg;
        ptr_next    = ptr_reg;
        cnt_next    = cnt_reg;
        number_next = number_reg;
        case (state_reg)
            IDLE: begin
                number_next = BLANK;
                cnt_next    = '0;
                if (win_found) begin
                    state_next = GRANT;
                    owner_next = win_idx;
                    ptr_next   = win_idx;
                end
            end
            GRANT: begin
                if (!req_ext[owner_reg]) begin
                    // Release wins over dwell expiry and other requests.
                    state_next  = IDLE;
                    owner_next  = 3'd0;
                    cnt_next    = '0;
                    number_next = BLANK;
                end else begin
                    // Old owner's data is still shown on the hand-over cycle.
                    number_next = slice_ext[owner_reg];
                    if (cnt_reg == CNT_MAX && win_found) begin
                        owner_next = win_idx;
                        ptr_next   = win_idx;
                        cnt_next   = '0;
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_next = cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= IDLE;
            owner_reg  <= 3'd0;
            ptr_reg    <= PTR_RESET;
            cnt_reg    <= '0;
            number_reg <= BLANK;
        end else begin
            state_reg  <= state_next;
            owner_reg  <= owner_next;
            ptr_reg    <= ptr_next;
            cnt_reg    <= cnt_next;
            number_reg <= number_next;
        end
    end
endmodule

// File: tb/tb_disp_arbiter.sv
// Testbench for disp_arbiter (N_REQ=3, DWELL=4): a cycle-level behavioural
// model checked every cycle, plus directed literal expectations.
module tb_disp_arbiter;
    localparam int          N     = 3;
    localparam int          DW    = 4;
    localparam logic [31:0] BLANK = 32'hFFFF_FFFF;
    localparam logic [31:0] D0    = 32'hC0F9_A4B0;
    localparam logic [31:0] D1    = 32'h9992_9282;
    localparam logic [31:0] D2    = 32'h1234_5678;
    localparam logic [31:0] NEW0  = 32'hA5A5_0F0F;
    localparam logic [31:0] NEW1  = 32'h5A5A_F0F0;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    disp_arbiter_if #(.N_REQ(N)) bus ();

    disp_arbiter #(
        .N_REQ(N), .DWELL(DW), .CNT_W(3), .BLANK(BLANK)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner is -1 when idle; held counts grant cycles so far.
    int          m_owner = -1;
    int          m_held  = 0;
    int          m_ptr   = N - 1;
    logic [31:0] m_num   = BLANK;

    function automatic int rr(input int ptr, input int excl, input logic [N-1:0] r);
        for (int off = 1; off <= N; off++) begin
            int c;
            c = (ptr + off) % N;
            if (c != excl && r[c]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int o, h, p, w;
        logic [31:0] nm;
        if (!rst_n) begin
            m_owner <= -1;
            m_held  <= 0;
            m_ptr   <= N - 1;
            m_num   <= BLANK;
        end else begin
            o = m_owner; h = m_held; p = m_ptr; nm = m_num;
            if (o < 0) begin
                nm = BLANK;
                w  = rr(p, -1, bus.req);
                if (w >= 0) begin o = w; p = w; h = 1; end
            end else if (!bus.req[o]) begin
                o = -1; h = 0; nm = BLANK;
            end else begin
                nm = bus.data[32*o +: 32];
                w  = rr(p, o, bus.req);
                if (h >= DW && w >= 0) begin o = w; p = w; h = 1; end
                else h = h + 1;
            end
            m_owner <= o; m_held <= h; m_ptr <= p; m_num <= nm;
        end
    end

    always @(negedge clk) begin
        chk("mdl_gnt",   32'(bus.gnt),   (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
        chk("mdl_owner", 32'(bus.owner), (m_owner < 0) ? 32'd0 : 32'(m_owner));
        chk("mdl_busy",  32'(bus.busy),  (m_owner < 0) ? 32'd0 : 32'd1);
        chk("mdl_num",   bus.number,     m_num);
    end

    initial begin
        bus.req  = 3'b111;
        bus.data = {D2, D1, D0};
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        $display("phase: reset release with req=111");
        rst_n = 1'b1;
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_num", bus.number, BLANK);
        @(negedge clk);
        chk("first_gnt", 32'(bus.gnt), 32'd1);
        chk("first_num", bus.number, BLANK);
        @(negedge clk);
        chk("first_data", bus.number, D0);

        bus.req = 3'b000;
        repeat (2) @(negedge clk);

        $display("phase: req=011 alternation");
        bus.req = 3'b011;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("alt_gnt", 32'(bus.gnt), ((i / 4) % 2 == 1) ? 32'd1 : 32'd2);
            chk("alt_num", bus.number,
                (i == 0) ? BLANK : ((((i - 1) / 4) % 2 == 1) ? D0 : D1));
        end

        bus.req = 3'b000;
        repeat (2) @(negedge clk);

        $display("phase: single requester, saturated dwell, then req2");
        bus.req = 3'b001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("solo_gnt", 32'(bus.gnt), 32'd1);
        end
        bus.req = 3'b101;
        @(negedge clk);
        chk("hand_gnt", 32'(bus.gnt), 32'd4);
        chk("hand_num", bus.number, D0);
        @(negedge clk);
        chk("hand_num2", bus.number, D2);

        bus.req = 3'b000;
        repeat (2) @(negedge clk);

        $display("phase: owner releases early");
        bus.req = 3'b011;
        @(negedge clk);
        chk("rel_gnt1", 32'(bus.gnt), 32'd1);
        @(negedge clk);
        chk("rel_gnt2", 32'(bus.gnt), 32'd1);
        bus.req = 3'b010;
        @(negedge clk);
        chk("rel_gap_gnt", 32'(bus.gnt), 32'd0);
        chk("rel_gap_num", bus.number, BLANK);
        chk("rel_gap_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("rel_next_gnt", 32'(bus.gnt), 32'd2);

        $display("phase: async reset mid-grant");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_gnt", 32'(bus.gnt), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_num", bus.number, BLANK);
        chk("arst_owner", 32'(bus.owner), 32'd0);
        bus.req = 3'b111;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_first_gnt", 32'(bus.gnt), 32'd1);

        $display("phase: owner / non-owner data change");
        bus.req = 3'b001;
        @(negedge clk);
        chk("live_num0", bus.number, D0);
        bus.data[31:0] = NEW0;
        @(negedge clk);
        chk("live_num1", bus.number, NEW0);
        bus.data[63:32] = NEW1;
        @(negedge clk);
        chk("live_num2", bus.number, NEW0);

        bus.req = 3'b000;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
